// File: rtl/full_adder.sv
// full_adder: registered WIDTH-bit ripple-carry adder with a valid flag.
// The port order keeps a, b, cin, sum, carry first, so positional
// instantiations of the legacy combinational cell still line up.
// Optional feature: define FULL_ADDER_OVERFLOW_EN to add a registered
// signed two's-complement overflow output.
module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             out_valid
`ifdef FULL_ADDER_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  logic [WIDTH-1:0] sum_next;
  logic             carry_next;

  // Ripple chain of one-bit full-adder stages, LSB first.
  always_comb begin
    logic c_run;
    // NOTE: c_run is a blocking temporary that carries each stage's carry into
    // the next stage; every output gets a default first so no latch is inferred.
    sum_next = '0;
    c_run    = cin;
    for (int i = 0; i < WIDTH; i++) begin
      sum_next[i] = a[i] ^ b[i] ^ c_run;
      c_run       = (a[i] & b[i]) | (a[i] & c_run) | (b[i] & c_run);
    end
    carry_next = c_run;
  end

`ifdef FULL_ADDER_OVERFLOW_EN
  logic overflow_next;

  // Signed overflow: operands share a sign and the result's sign differs.
  always_comb begin
    overflow_next = (a[WIDTH-1] == b[WIDTH-1]) && (sum_next[WIDTH-1] != a[WIDTH-1]);
  end
`endif

  // Output registers: capture on valid, otherwise hold; out_valid tracks in_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum       <= '0;
      carry     <= 1'b0;
      out_valid <= 1'b0;
`ifdef FULL_ADDER_OVERFLOW_EN
      overflow  <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments; leaving sum/carry
      // unassigned when in_valid=0 is a clocked hold (flop enable), not a latch,
      // and it keeps X/Z on idle operands away from the held result.
      out_valid <= in_valid;
      if (in_valid) begin
        sum   <= sum_next;
        carry <= carry_next;
`ifdef FULL_ADDER_OVERFLOW_EN
        overflow <= overflow_next;
`endif
      end
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: drives WIDTH=1, 8 and 16 instances of full_adder and checks
// them against a reference model built from plain integer addition.
// Define FULL_ADDER_OVERFLOW_EN to also check the overflow output.
module tb_full_adder;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic        a1, b1, cin1, v1, sum1, carry1, ov_valid1;
  logic [7:0]  a8, b8, sum8;
  logic        cin8, v8, carry8, ov_valid8;
  logic [15:0] a16, b16, sum16;
  logic        cin16, v16, carry16, ov_valid16;
`ifdef FULL_ADDER_OVERFLOW_EN
  logic        ovf1, ovf8, ovf16;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state: last accepted result per instance.
  logic [8:0]  exp8;
  logic [16:0] exp16;
  bit          exp_ovf8, exp_ovf16;

  always #5 clk = ~clk;

  full_adder #(.WIDTH(1)) u_w1 (
    .a(a1), .b(b1), .cin(cin1), .sum(sum1), .carry(carry1),
    .clk(clk), .rst(rst), .in_valid(v1), .out_valid(ov_valid1)
`ifdef FULL_ADDER_OVERFLOW_EN
    , .overflow(ovf1)
`endif
  );

  full_adder #(.WIDTH(8)) u_w8 (
    .a(a8), .b(b8), .cin(cin8), .sum(sum8), .carry(carry8),
    .clk(clk), .rst(rst), .in_valid(v8), .out_valid(ov_valid8)
`ifdef FULL_ADDER_OVERFLOW_EN
    , .overflow(ovf8)
`endif
  );

  full_adder #(.WIDTH(16)) u_w16 (
    .a(a16), .b(b16), .cin(cin16), .sum(sum16), .carry(carry16),
    .clk(clk), .rst(rst), .in_valid(v16), .out_valid(ov_valid16)
`ifdef FULL_ADDER_OVERFLOW_EN
    , .overflow(ovf16)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Signed overflow from the definition: the true signed result leaves the range.
  function automatic bit signed_ovf(input longint sa, input longint sb, input bit c, input int w);
    longint r;
    longint lim;
    lim = longint'(1) << (w - 1);
    r   = sa + sb + longint'(c);
    return (r > lim - 1) || (r < -lim);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply8(input logic [7:0] a, input logic [7:0] b, input logic c);
    a8 = a; b8 = b; cin8 = c; v8 = 1'b1;
    exp8     = 9'(a) + 9'(b) + 9'(c);
    exp_ovf8 = signed_ovf(longint'($signed(a)), longint'($signed(b)), c, 8);
  endtask

  task automatic check8(input string tag, input bit exp_valid);
    check({tag, "_sum"}, 64'({carry8, sum8}), 64'(exp8));
    check({tag, "_vld"}, 64'(ov_valid8), 64'(exp_valid));
`ifdef FULL_ADDER_OVERFLOW_EN
    check({tag, "_ovf"}, 64'(ovf8), 64'(exp_ovf8));
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_w1"},  64'({carry1, sum1, ov_valid1}), 64'(0));
    check({tag, "_w8"},  64'({carry8, sum8, ov_valid8}), 64'(0));
    check({tag, "_w16"}, 64'({carry16, sum16, ov_valid16}), 64'(0));
`ifdef FULL_ADDER_OVERFLOW_EN
    check({tag, "_ovf"}, 64'({ovf1, ovf8, ovf16}), 64'(0));
`endif
  endtask

  // Watchdog: the bench must never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    a1 = 0; b1 = 0; cin1 = 0; v1 = 0;
    a8 = 0; b8 = 0; cin8 = 0; v8 = 0;
    a16 = 0; b16 = 0; cin16 = 0; v16 = 0;
    exp8 = '0; exp_ovf8 = 0; exp16 = '0; exp_ovf16 = 0;

    // Asynchronous reset takes effect between clock edges.
    #2 rst = 1'b1;
    #1 check_all_zero("rst_async");

    // Valid input while in reset is ignored.
    v1 = 1; a1 = 1; b1 = 1; cin1 = 1;
    apply8(8'hFF, 8'hFF, 1'b1);
    v16 = 1; a16 = 16'hFFFF; b16 = 16'h1; cin16 = 1;
    tick();
    check_all_zero("rst_ignore");

    // Release; an idle first edge leaves everything at zero.
    rst = 1'b0;
    v1 = 0; v8 = 0; v16 = 0;
    exp8 = '0; exp_ovf8 = 0;
    tick();
    check_all_zero("post_rst_idle");

    // WIDTH=1: all eight input combinations, back to back.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] combo;
      int ones;
      combo = 3'(i);
      {a1, b1, cin1} = combo;
      v1 = 1'b1;
      ones = int'(combo[2]) + int'(combo[1]) + int'(combo[0]);
      tick();
      check($sformatf("w1_combo%0d", i), 64'({carry1, sum1}), 64'(ones));
      check($sformatf("w1_vld%0d", i), 64'(ov_valid1), 64'(1));
    end
    v1 = 1'b0;

    // WIDTH=8 boundaries and overflow corners.
    apply8(8'hFF, 8'hFF, 1'b1); tick(); check8("w8_allones", 1'b1);
    apply8(8'h80, 8'h80, 1'b0); tick(); check8("w8_8080", 1'b1);
    apply8(8'h00, 8'h00, 1'b0); tick(); check8("w8_zero", 1'b1);
    apply8(8'h7F, 8'h01, 1'b0); tick(); check8("w8_posovf", 1'b1);
    apply8(8'h7F, 8'h80, 1'b1); tick(); check8("w8_mixsign", 1'b1);

    // Hold: one valid transaction, then three idle cycles with junk operands.
    apply8(8'h12, 8'h34, 1'b0); tick(); check8("w8_1234", 1'b1);
    for (int i = 0; i < 3; i++) begin
      v8 = 1'b0;
      if (i == 0) begin
        a8 = 'x; b8 = 'x; cin8 = 1'bx;
      end else begin
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      end
      tick();
      check8($sformatf("w8_hold%0d", i), 1'b0);
    end

    // Reset mid-stream, between edges: outputs clear at once.
    apply8(8'hA5, 8'h3C, 1'b1); tick(); check8("w8_pre_rst", 1'b1);
    apply8(8'h11, 8'h22, 1'b0);
    #2 rst = 1'b1;
    #1 check_all_zero("rst_mid");
    // Input presented alongside reset is discarded.
    tick();
    rst = 1'b0;
    v8 = 1'b0;
    exp8 = '0; exp_ovf8 = 0;
    tick();
    check8("w8_discard", 1'b0);
    apply8(8'hC8, 8'h64, 1'b1); tick(); check8("w8_after_rst", 1'b1);

    // WIDTH=8: random valid/idle mix against the holding model.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        apply8(8'($urandom), 8'($urandom), 1'($urandom));
        tick();
        check8("w8_rand", 1'b1);
      end else begin
        v8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        tick();
        check8("w8_rand_idle", 1'b0);
      end
    end
    v8 = 1'b0;

    // WIDTH=16: 1000 consecutive valid operands, one result per cycle.
    for (int i = 0; i < 1000; i++) begin
      a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom); v16 = 1'b1;
      exp16     = 17'(a16) + 17'(b16) + 17'(cin16);
      exp_ovf16 = signed_ovf(longint'($signed(a16)), longint'($signed(b16)), cin16, 16);
      tick();
      check("w16_sum", 64'({carry16, sum16}), 64'(exp16));
      check("w16_vld", 64'(ov_valid16), 64'(1));
`ifdef FULL_ADDER_OVERFLOW_EN
      check("w16_ovf", 64'(ovf16), 64'(exp_ovf16));
`endif
    end
    v16 = 1'b0;
    tick();
    check("w16_idle_vld", 64'(ov_valid16), 64'(0));
    check("w16_idle_hold", 64'({carry16, sum16}), 64'(exp16));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/full_adder.md
FULL_ADDER -- requirements
Module: full_adder

Interface
REQ-001 Parameter WIDTH, default 1, operand width in bits (legal range 1..64).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 a  input  WIDTH  first operand, unsigned.
REQ-005 b  input  WIDTH  second operand, unsigned.
REQ-006 cin  input  1  carry-in.
REQ-007 in_valid  input  1  qualifies a/b/cin this cycle.
REQ-008 sum  output  WIDTH  registered sum.
REQ-009 carry  output  1  registered carry-out.
REQ-010 out_valid  output  1  qualifies sum/carry.
REQ-011 Port order SHALL be a, b, cin, sum, carry, then clk, rst, in_valid, out_valid, so positional instantiation of the first five ports matches the legacy combinational cell.

Function
REQ-012 The datapath SHALL be a ripple chain of WIDTH one-bit full-adder stages; stage i: s = a[i]^b[i]^c[i], c[i+1] = a[i]&b[i] | a[i]&c[i] | b[i]&c[i], with c[0] = cin.
REQ-013 {carry, sum} SHALL equal a + b + cin, computed to WIDTH+1 bits with no truncation.
REQ-014 Latency SHALL be exactly 1 cycle: when in_valid=1 at edge N, sum/carry hold the result and out_valid=1 after edge N.
REQ-015 When in_valid=0 at an edge, sum/carry SHALL hold their previous values and out_valid SHALL go 0.
REQ-016 Back-to-back valid inputs SHALL be accepted every cycle with no stalls; no backpressure input.
REQ-017 Boundary: a=b=all-ones, cin=1 SHALL give sum=all-ones, carry=1; a=b=0, cin=0 SHALL give sum=0, carry=0.
REQ-018 X/Z on a/b/cin while in_valid=0 SHALL NOT affect held outputs.

Reset
REQ-019 Asserting rst SHALL immediately, without a clock edge, force sum=0, carry=0, out_valid=0.
REQ-020 While rst=1, in_valid SHALL be ignored; the first capture occurs on the first rising edge after rst deasserts.
REQ-021 Reset asserted in the same cycle as in_valid=1 SHALL discard that input; no result appears after release.

Configuration
REQ-022 Macro FULL_ADDER_OVERFLOW_EN: when defined, the SHALL add output overflow (1 bit, registered, same timing as sum) equal to signed two's-complement overflow, (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]), reset to 0.
REQ-023 When FULL_ADDER_OVERFLOW_EN is undefined, the overflow port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-024 WIDTH=1, apply all 8 {a,b,cin} combos 000..111, one per cycle with in_valid=1 -> {carry,sum} = 00,01,01,10,01,10,10,11 one cycle later, each with out_valid=1.
REQ-025 WIDTH=8, a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, carry=1; a=8'h80, b=8'h80, cin=0 -> sum=8'h00, carry=1, overflow=1 when the macro is enabled.
REQ-026 WIDTH=8, valid a=8'h12, b=8'h34, then in_valid=0 for 3 cycles with random a/b -> sum holds 8'h46, out_valid=0 after the first idle edge.
REQ-027 Assert rst mid-stream between clock edges -> sum=0, carry=0, out_valid=0 immediately; after release, the next valid input yields correct results after 1 cycle.
REQ-028 WIDTH=16, random valid operands every cycle for 1000 cycles -> {carry,sum} matches a+b+cin from the previous cycle with no gaps.
